nt_level_accumulator: RTL
=========================

NT_LEVEL_ACCUMULATOR -- requirements
Module: nt_level_accumulator

Interface
REQ-001 SHALL take parameter LEVEL_W, default 8: neurotransmitter level width in bits (min 4).
REQ-002 SHALL take parameter PRESC_DIV, default 4: en pulses per update tick (min 1).
REQ-003 SHALL take parameter FAST_STEP, default 4: step size when fast=1 (min 1, less than 2^LEVEL_W).
REQ-004 SHALL take parameter DECAY_DIV, default 8: idle ticks per one-step decay toward baseline (min 1).
REQ-005 SHALL take parameter HYST, default 4: band hysteresis margin in LSBs (less than Q/2, where Q = 2^(LEVEL_W-2)).
REQ-006 SHALL take parameter RESET_LEVEL, default 2^(LEVEL_W-1): level value loaded on reset.
REQ-007 SHALL have port clk, input, 1 bit: the single clock.
REQ-008 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-009 SHALL have port en, input, 1 bit: prescaler advance strobe.
REQ-010 SHALL have ports inc, dec and fast, each input, 1 bit: regulator requests.
REQ-011 SHALL have port baseline, input, LEVEL_W bits: decay target.
REQ-012 SHALL have port level, output, LEVEL_W bits: registered level.
REQ-013 SHALL have port band, output, 2 bits: quantised level, formatted as a 2-bit field of neurotransmitter_level.
REQ-014 SHALL have ports sat_hi and sat_lo, each output, 1 bit: level==2^LEVEL_W-1 and level==0 respectively.

Function
REQ-015 SHALL keep a prescaler count that advances only on cycles with en=1 and raises tick on the en=1 cycle where count==PRESC_DIV-1; the count then wraps to 0.
REQ-016 SHALL sample inc, dec and fast only in tick cycles; the new level is visible one cycle after the tick cycle.
REQ-017 SHALL use step = FAST_STEP when fast=1, else 1.
REQ-018 On a tick with dec=1, SHALL compute level-step, clamped at 0; dec dominates when inc=1 too.
REQ-019 On a tick with inc=1 and dec=0, SHALL compute level+step, clamped at 2^LEVEL_W-1; arithmetic SHALL be one bit wider than level, with no wrap-around.
REQ-020 SHALL keep a decay counter that clears on any tick with inc or dec set and increments on ticks with neither.
REQ-021 On the idle tick where the decay counter equals DECAY_DIV-1, SHALL move level one LSB toward baseline (no change if equal) and clear the counter.
REQ-022 SHALL compute sat_hi and sat_lo combinationally from the level register.
REQ-023 SHALL hold level and both counters on non-tick cycles.
REQ-024 Band thresholds SHALL be multiples of Q; one band step per cycle; band lags level by one cycle.
REQ-025 SHALL take a baseline change effect only at the next decay step; it SHALL NOT clear the counters.

Reset
REQ-026 When rst_n=0, SHALL set immediately, independent of clk: level=RESET_LEVEL, both counters=0, band=RESET_LEVEL[LEVEL_W-1:LEVEL_W-2], sat flags per REQ-014.
REQ-027 A reset asserted mid-tick SHALL discard the pending update; the first tick after release SHALL need PRESC_DIV en pulses.

Configuration
REQ-028 With NT_HYSTERESIS_EN defined, band SHALL be a register: it rises from b to b+1 when level >= (b+1)*Q+HYST and falls from b to b-1 when level < b*Q-HYST.
REQ-029 Without NT_HYSTERESIS_EN, band SHALL equal level[LEVEL_W-1:LEVEL_W-2] combinationally, and the HYST parameter SHALL be unused.

Structure
REQ-030 Band encodings (LOW=00, MID_LO=01, MID_HI=10, HIGH=11) SHALL live in shared package nt_pkg.
REQ-031 The prescaler SHALL be a sub-module nt_tick_prescaler (clk, rst_n, en, tick), parameterised by PRESC_DIV.

Verification
All scenarios use default parameters; "then" means after the stated stimulus completes.
REQ-032 Release reset -> level=128, band=10, sat_hi=0, sat_lo=0.
REQ-033 en=1, inc=1, fast=0 for 16 cycles -> level=132; repeat with fast=1 -> level=148.
REQ-034 inc=1 and dec=1 with fast=1 at a tick from 128 -> level=124.
REQ-035 From level 254, inc=1 fast=1 on one tick -> 255, sat_hi=1. From level 2, dec=1 fast=1 on one tick -> 0, sat_lo=1.
REQ-036 Level 140, baseline 128, en=1, no requests -> after 32 cycles level=139; with inc pulsed at the 5th tick, the next decay step moves 8 ticks later.
REQ-037 NT_HYSTERESIS_EN defined: drop level 128 to 127 -> band stays 10; to 123 -> band 01; back to 128 -> band stays 01; to 132 -> band 10. Without the macro: level 127 -> band 01 in the same cycle.

Source files
------------

// File: rtl/nt_pkg.sv
// Shared encodings for the neurotransmitter level accumulator.
// Band codes name the four quarters of the level range.
package nt_pkg;

   typedef enum logic [1:0] {
      BAND_LOW    = 2'b00,
      BAND_MID_LO = 2'b01,
      BAND_MID_HI = 2'b10,
      BAND_HIGH   = 2'b11
   } nt_band_e;

   // Default band of a level is its top two bits (quarter of the range).
   function automatic logic [1:0] band_of_msbs(input logic [1:0] msbs);
      return msbs;
   endfunction

endpackage

// File: rtl/nt_tick_prescaler.sv
// Divides the en strobe by PRESC_DIV; tick fires combinationally on the
// en cycle that completes a group of PRESC_DIV pulses.
module nt_tick_prescaler #(
   parameter int PRESC_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int CW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = en && (cnt_q == CW'(PRESC_DIV - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (en) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/nt_level_accumulator.sv
// Saturating neurotransmitter level with prescaled updates and idle decay
// toward baseline. Define NT_HYSTERESIS_EN for a registered, hysteretic band.
module nt_level_accumulator
   import nt_pkg::*;
#(
   parameter int LEVEL_W     = 8,
   parameter int PRESC_DIV   = 4,
   parameter int FAST_STEP   = 4,
   parameter int DECAY_DIV   = 8,
   parameter int HYST        = 4,
   parameter int RESET_LEVEL = 2 ** (LEVEL_W - 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               inc,
   input  logic               dec,
   input  logic               fast,
   input  logic [LEVEL_W-1:0] baseline,
   output logic [LEVEL_W-1:0] level,
   output logic [1:0]         band,
   output logic               sat_hi,
   output logic               sat_lo
);

   localparam int Q      = 2 ** (LEVEL_W - 2);
   localparam int DCNT_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
   localparam logic [LEVEL_W-1:0] RST_LVL = LEVEL_W'(RESET_LEVEL);
   localparam logic [LEVEL_W-1:0] LVL_MAX = '1;

   if (LEVEL_W < 4 || PRESC_DIV < 1 || FAST_STEP < 1 || DECAY_DIV < 1 ||
       FAST_STEP >= 2 ** LEVEL_W || HYST < 0 || HYST >= Q / 2) begin : g_param_chk
      $error("nt_level_accumulator: parameter out of range");
   end

   logic                tick;
   logic [LEVEL_W-1:0]  level_q, level_d;
   logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
   logic [LEVEL_W:0]    step;

   // One-bit-wider arithmetic; the extra bit flags overflow/borrow.
   function automatic logic [LEVEL_W-1:0] sat_add(input logic [LEVEL_W-1:0] a,
                                                  input logic [LEVEL_W:0]   s);
      logic [LEVEL_W:0] r;
      r = {1'b0, a} + s;
      return r[LEVEL_W] ? LVL_MAX : r[LEVEL_W-1:0];
   endfunction

   function automatic logic [LEVEL_W-1:0] sat_sub(input logic [LEVEL_W-1:0] a,
                                                  input logic [LEVEL_W:0]   s);
      logic [LEVEL_W:0] r;
      r = {1'b0, a} - s;
      return r[LEVEL_W] ? '0 : r[LEVEL_W-1:0];
   endfunction

   nt_tick_prescaler #(
      .PRESC_DIV(PRESC_DIV)
   ) u_presc (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .tick (tick)
   );

   assign step = fast ? (LEVEL_W + 1)'(FAST_STEP) : (LEVEL_W + 1)'(1);

   always_comb begin
      level_d = level_q;
      dcnt_d  = dcnt_q;
      if (tick) begin
         if (dec) begin
            level_d = sat_sub(level_q, step);
            dcnt_d  = '0;
         end else if (inc) begin
            level_d = sat_add(level_q, step);
            dcnt_d  = '0;
         end else if (dcnt_q == DCNT_W'(DECAY_DIV - 1)) begin
            dcnt_d = '0;
            if (level_q < baseline) begin
               level_d = level_q + 1'b1;
            end else if (level_q > baseline) begin
               level_d = level_q - 1'b1;
            end
         end else begin
            dcnt_d = dcnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q <= RST_LVL;
         dcnt_q  <= '0;
      end else begin
         level_q <= level_d;
         dcnt_q  <= dcnt_d;
      end
   end

   assign level  = level_q;
   assign sat_hi = (level_q == LVL_MAX);
   assign sat_lo = (level_q == '0);

`ifdef NT_HYSTERESIS_EN
   logic [1:0] band_q, band_d;
   int         up_thr, dn_thr;

   // Moves at most one band per cycle, so large level jumps take several cycles.
   always_comb begin
      band_d = band_q;
      up_thr = (int'(band_q) + 1) * Q + HYST;
      dn_thr = int'(band_q) * Q - HYST;
      if (band_q != BAND_HIGH && int'(level_q) >= up_thr) begin
         band_d = band_q + 1'b1;
      end else if (band_q != BAND_LOW && int'(level_q) < dn_thr) begin
         band_d = band_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         band_q <= band_of_msbs(RST_LVL[LEVEL_W-1 -: 2]);
      end else begin
         band_q <= band_d;
      end
   end

   assign band = band_q;
`else
   assign band = band_of_msbs(level_q[LEVEL_W-1 -: 2]);
`endif

endmodule
